// File: rtl/pipe2_decode_reg.sv
// Decode-stage pipeline register with valid/allowin handshake,
// hazard-stall accounting and a sticky stall-timeout flag.
module pipe2_decode_reg #(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pipe1_valid,
  input  logic [31:0]      pipe1_inst,
  input  logic [31:0]      pipe1_pc,
  output logic             pipe2_allowin,
  input  logic             not_ready_to_go,
  input  logic             pipe3_allowin,
  input  logic             flush,
  output logic             pipe2_to_pipe3_valid,
  output logic             pipe2_valid,
  output logic [31:0]      pipe2_inst,
  output logic [31:0]      pipe2_pc,
  output logic [4:0]       pipe2_read_dest1,
  output logic [4:0]       pipe2_read_dest2,
  output logic             pipe2_use_reg_op,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_timeout
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    VALID = 2'b01,
    STALL = 2'b10
  } state_t;

  localparam logic [2:0] MAX_RUN = 3'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_q;
  state_t      state_d;
  logic        ready_go;
  logic        valid_d;
  logic        stall_hit;
  logic        op_no_reg;
  logic [5:0]  opcode;
  logic [2:0]  run_q;
  logic [2:0]  run_d;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  assign ready_go    = ~not_ready_to_go;
  assign pipe2_valid = (state_q != EMPTY);
  assign pipe2_inst  = inst_q;
  assign pipe2_pc    = pc_q;

  assign pipe2_allowin =
    ~pipe2_valid | (ready_go & pipe3_allowin);
  assign pipe2_to_pipe3_valid =
    pipe2_valid & ready_go & ~flush;

  // Stalls only count against a live, surviving instruction.
  assign stall_hit =
    pipe2_valid & not_ready_to_go & ~flush;

  assign pipe2_read_dest1 = inst_q[25:21];
  assign pipe2_read_dest2 = inst_q[20:16];
  assign opcode           = inst_q[31:26];

  always_comb begin
    op_no_reg = 1'b0;
    unique case (1'b1)
      opcode == 6'h02: op_no_reg = 1'b1;
      opcode == 6'h03: op_no_reg = 1'b1;
      opcode == 6'h0f: op_no_reg = 1'b1;
      default:         op_no_reg = 1'b0;
    endcase
  end

  assign pipe2_use_reg_op =
    pipe2_valid & (inst_q != 32'd0) & ~op_no_reg;

  always_comb begin
    valid_d = pipe2_valid;
    if (flush)
      valid_d = 1'b0;
    else if (pipe2_allowin)
      valid_d = pipe1_valid;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      !valid_d:                   state_d = EMPTY;
      valid_d && not_ready_to_go: state_d = STALL;
      valid_d && ready_go:        state_d = VALID;
      default:                    state_d = EMPTY;
    endcase
  end

  always_comb begin
    run_d = 3'd0;
    if (stall_hit)
      run_d = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      inst_q  <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (!flush && pipe2_allowin && pipe1_valid) begin
        inst_q <= pipe1_inst;
        pc_q   <= pipe1_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q         <= 3'd0;
      stall_count   <= '0;
      stall_timeout <= 1'b0;
    end else begin
      run_q <= run_d;
      if (stall_hit && !(&stall_count))
        stall_count <= stall_count + CNT_ONE;
      // Run would pass the limit on this edge.
      if (stall_hit && run_q >= MAX_RUN)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe2_decode_reg.sv
// Bench for pipe2_decode_reg: directed vector table, decode table,
// randomized run against a reference model, mid-stall reset.
module tb_pipe2_decode_reg;

  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pipe1_valid;
  logic [31:0] pipe1_inst;
  logic [31:0] pipe1_pc;
  logic        pipe2_allowin;
  logic        not_ready_to_go;
  logic        pipe3_allowin;
  logic        flush;
  logic        pipe2_to_pipe3_valid;
  logic        pipe2_valid;
  logic [31:0] pipe2_inst;
  logic [31:0] pipe2_pc;
  logic [4:0]  pipe2_read_dest1;
  logic [4:0]  pipe2_read_dest2;
  logic        pipe2_use_reg_op;
  logic [31:0] stall_count;
  logic        stall_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  pipe2_decode_reg #(.CNT_W(32), .MAX_STALL(MAXS)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .pipe1_valid         (pipe1_valid),
    .pipe1_inst          (pipe1_inst),
    .pipe1_pc            (pipe1_pc),
    .pipe2_allowin       (pipe2_allowin),
    .not_ready_to_go     (not_ready_to_go),
    .pipe3_allowin       (pipe3_allowin),
    .flush               (flush),
    .pipe2_to_pipe3_valid(pipe2_to_pipe3_valid),
    .pipe2_valid         (pipe2_valid),
    .pipe2_inst          (pipe2_inst),
    .pipe2_pc            (pipe2_pc),
    .pipe2_read_dest1    (pipe2_read_dest1),
    .pipe2_read_dest2    (pipe2_read_dest2),
    .pipe2_use_reg_op    (pipe2_use_reg_op),
    .stall_count         (stall_count),
    .stall_timeout       (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        p1v;
    logic [31:0] pc;
    logic        nrtg;
    logic        p3a;
    logic        fl;
    logic        e_allow;
    logic        e_to3;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_cnt;
    logic        e_to;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        e_use;
    logic [4:0]  e_d1;
    logic [4:0]  e_d2;
  } dec_t;

  function automatic vec_t mk(
    logic p1v, logic [31:0] pc, logic nrtg, logic p3a,
    logic fl, logic e_allow, logic e_to3, logic e_valid,
    logic [31:0] e_pc, int e_cnt, logic e_to);
    vec_t v;
    v.p1v = p1v; v.pc = pc; v.nrtg = nrtg;
    v.p3a = p3a; v.fl = fl; v.e_allow = e_allow;
    v.e_to3 = e_to3; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_to = e_to;
    return v;
  endfunction

  function automatic dec_t mkd(logic [31:0] inst,
    logic e_use, logic [4:0] e_d1, logic [4:0] e_d2);
    dec_t d;
    d.inst = inst; d.e_use = e_use;
    d.e_d1 = e_d1; d.e_d2 = e_d2;
    return d;
  endfunction

  task automatic drive(input logic p1v,
                       input logic [31:0] inst,
                       input logic [31:0] pc,
                       input logic nrtg,
                       input logic p3a,
                       input logic fl);
    pipe1_valid     = p1v;
    pipe1_inst      = inst;
    pipe1_pc        = pc;
    not_ready_to_go = nrtg;
    pipe3_allowin   = p3a;
    flush           = fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic no_reg_op(logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    return (op == 6'h02) || (op == 6'h03) ||
           (op == 6'h0f);
  endfunction

  vec_t vecs[$];
  dec_t decs[$];

  // reference model state
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  longint      m_cnt;
  int          m_run;
  logic        m_to;

  localparam logic [31:0] LW = 32'h8C22_0004;

  initial begin
    resetn = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // p1v pc nrtg p3a fl | allow to3 | valid pc cnt to
    vecs.push_back(mk(1,'h100,0,1,0, 1,0, 1,'h100,0,0));
    vecs.push_back(mk(1,'h104,0,1,0, 1,1, 1,'h104,0,0));
    vecs.push_back(mk(1,'h108,0,1,0, 1,1, 1,'h108,0,0));
    vecs.push_back(mk(1,'h200,0,1,0, 1,1, 1,'h200,0,0));
    vecs.push_back(mk(1,'h204,1,1,0, 0,0, 1,'h200,1,0));
    vecs.push_back(mk(1,'h204,1,1,0, 0,0, 1,'h200,2,0));
    vecs.push_back(mk(1,'h204,0,1,0, 1,1, 1,'h204,2,0));
    vecs.push_back(mk(1,'h208,1,1,0, 0,0, 1,'h204,3,0));
    vecs.push_back(mk(1,'h208,1,1,0, 0,0, 1,'h204,4,0));
    vecs.push_back(mk(1,'h208,1,1,0, 0,0, 1,'h204,5,0));
    vecs.push_back(mk(1,'h208,1,1,0, 0,0, 1,'h204,6,1));
    vecs.push_back(mk(1,'h208,0,1,0, 1,1, 1,'h208,6,1));
    vecs.push_back(mk(1,'h20c,1,1,0, 0,0, 1,'h208,7,1));
    vecs.push_back(mk(1,'h300,1,1,1, 0,0, 0,'h208,7,1));
    vecs.push_back(mk(1,'h300,0,1,0, 1,0, 1,'h300,7,1));
    vecs.push_back(mk(1,'h304,0,1,1, 1,0, 0,'h300,7,1));
    vecs.push_back(mk(1,'h400,0,1,0, 1,0, 1,'h400,7,1));
    vecs.push_back(mk(1,'h404,0,0,0, 0,1, 1,'h400,7,1));
    vecs.push_back(mk(1,'h404,0,0,0, 0,1, 1,'h400,7,1));
    vecs.push_back(mk(1,'h404,0,0,0, 0,1, 1,'h400,7,1));
    vecs.push_back(mk(0,'h000,0,1,1, 1,0, 0,'h400,7,1));
    vecs.push_back(mk(0,'h000,1,1,0, 1,0, 0,'h400,7,1));

    decs.push_back(mkd(32'h0000_0000, 0, 0, 0));
    decs.push_back(mkd(32'h3C01_0001, 0, 0, 1));
    decs.push_back(mkd(32'h8C22_0004, 1, 1, 2));
    decs.push_back(mkd(32'h0800_0010, 0, 0, 0));
    decs.push_back(mkd(32'h0C00_0000, 0, 0, 0));
    decs.push_back(mkd(32'h0085_1021, 1, 4, 5));

    do_reset();
    #1;
    chk("rst_valid",   pipe2_valid,   0);
    chk("rst_allowin", pipe2_allowin, 1);
    chk("rst_cnt",     stall_count,   0);
    chk("rst_to",      stall_timeout, 0);
    chk("rst_pc",      pipe2_pc,      0);
    chk("rst_inst",    pipe2_inst,    0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive(v.p1v, LW, v.pc, v.nrtg, v.p3a, v.fl);
      #1;
      chk($sformatf("v%0d_allowin", i),
          pipe2_allowin, v.e_allow);
      chk($sformatf("v%0d_to3", i),
          pipe2_to_pipe3_valid, v.e_to3);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), pipe2_valid, v.e_valid);
      chk($sformatf("v%0d_pc", i),    pipe2_pc,    v.e_pc);
      chk($sformatf("v%0d_cnt", i),   stall_count, v.e_cnt);
      chk($sformatf("v%0d_to", i),    stall_timeout, v.e_to);
    end

    foreach (decs[i]) begin
      @(negedge clk);
      drive(1'b1, decs[i].inst, 32'h500, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("d%0d_use", i),
          pipe2_use_reg_op, decs[i].e_use);
      chk($sformatf("d%0d_d1", i),
          pipe2_read_dest1, decs[i].e_d1);
      chk($sformatf("d%0d_d2", i),
          pipe2_read_dest2, decs[i].e_d2);
    end

    // randomized run against the reference model
    do_reset();
    m_valid = 0; m_inst = 0; m_pc = 0;
    m_cnt = 0; m_run = 0; m_to = 0;
    for (int c = 0; c < 400; c++) begin
      logic        r_p1v, r_nrtg, r_p3a, r_fl, m_allow;
      logic [31:0] r_inst;
      r_p1v  = ($urandom_range(0, 3) != 0);
      r_nrtg = ($urandom_range(0, 9) < 4);
      r_p3a  = ($urandom_range(0, 3) != 0);
      r_fl   = ($urandom_range(0, 9) == 0);
      r_inst = $urandom;
      case ($urandom_range(0, 5))
        0: r_inst = 32'd0;
        1: r_inst[31:26] = 6'h02;
        2: r_inst[31:26] = 6'h03;
        3: r_inst[31:26] = 6'h0f;
        default: ;
      endcase
      @(negedge clk);
      drive(r_p1v, r_inst, $urandom, r_nrtg, r_p3a, r_fl);
      #1;
      m_allow = !m_valid || (!r_nrtg && r_p3a);
      chk("r_allowin", pipe2_allowin, m_allow);
      chk("r_to3", pipe2_to_pipe3_valid,
          m_valid && !r_nrtg && !r_fl);
      chk("r_use", pipe2_use_reg_op,
          m_valid && m_inst != 0 && !no_reg_op(m_inst));
      chk("r_d1", pipe2_read_dest1, m_inst[25:21]);
      chk("r_d2", pipe2_read_dest2, m_inst[20:16]);
      if (m_valid && r_nrtg && !r_fl) begin
        m_run++;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_run > MAXS) m_to = 1;
      end else begin
        m_run = 0;
      end
      if (r_fl) begin
        m_valid = 0;
      end else if (m_allow) begin
        m_valid = r_p1v;
        if (r_p1v) begin
          m_inst = pipe1_inst;
          m_pc   = pipe1_pc;
        end
      end
      @(posedge clk);
      #1;
      chk("r_valid", pipe2_valid,   m_valid);
      chk("r_inst",  pipe2_inst,    m_inst);
      chk("r_pc",    pipe2_pc,      m_pc);
      chk("r_cnt",   stall_count,   m_cnt);
      chk("r_to",    stall_timeout, m_to);
    end

    // reset lands in the middle of a stall run
    do_reset();
    @(negedge clk);
    drive(1'b1, LW, 32'h600, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, LW, 32'h604, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_cnt_pre", stall_count,   3);
    chk("mid_to_pre",  stall_timeout, 0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", pipe2_valid,   0);
    chk("mid_rst_cnt",   stall_count,   0);
    chk("mid_rst_to",    stall_timeout, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, LW, 32'h700, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, LW, 32'h704, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_cnt", stall_count,   3);
    chk("post_to",  stall_timeout, 0);
    chk("post_pc",  pipe2_pc,      32'h700);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
